// File: rtl/csr_pkg.sv
// Shared CSR index map, mstatus bit positions, cause codes and the trap
// sequencer state encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h000;
  localparam logic [11:0] CSR_MTVEC   = 12'h005;
  localparam logic [11:0] CSR_MEPC    = 12'h041;
  localparam logic [11:0] CSR_MCAUSE  = 12'h042;
  localparam logic [11:0] CSR_MTVAL   = 12'h043;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_TVAL,
    ST_UPD_STATUS,
    ST_VEC_TRAP,
    ST_RST_STATUS,
    ST_VEC_MRET
  } state_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap/MRET sequencer sharing the single CSR port with the instruction path.
// Build option CSR_TRAP_TVAL_EN adds an MTVAL save step to the trap sequence.
//   state      | meaning
//   IDLE       | pass-through, accept trap/MRET    SAVE_EPC/CAUSE/TVAL | write mepc/mcause/mtval
//   UPD_STATUS | mstatus RMW on trap entry         VEC_TRAP            | redirect to mtvec
//   RST_STATUS | mstatus RMW on MRET               VEC_MRET            | redirect to mepc
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ins_req,
  input  logic               ins_csr_w,
  input  logic [11:0]        ins_csr,
  input  logic [XLEN-1:0]    ins_wd,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret_valid,
  output logic               exc_ack,
  output logic               csr_w,
  output logic [11:0]        csr,
  output logic [XLEN-1:0]    wd,
  input  logic [XLEN-1:0]    rd,
  output logic               stall,
  output logic               redir_valid,
  output logic [XLEN-1:0]    redir_pc
);

  state_e             state_q, state_d;
  logic [XLEN-1:2]    pc_q, pc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

`ifdef CSR_TRAP_TVAL_EN
  logic [XLEN-1:0] tval_q, tval_d;
  logic            unused_bits;
  assign unused_bits = ^exc_pc[1:0];
`else
  logic            unused_bits;
  assign unused_bits = ^{exc_pc[1:0], exc_tval};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
`ifdef CSR_TRAP_TVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
`ifdef CSR_TRAP_TVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
`ifdef CSR_TRAP_TVAL_EN
    tval_d      = tval_q;
`endif
    exc_ack     = 1'b0;
    csr_w       = 1'b0;
    csr         = '0;
    wd          = '0;
    stall       = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;

    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          exc_ack = 1'b1;
          pc_d    = exc_pc[XLEN-1:2];
          cause_d = exc_cause;
`ifdef CSR_TRAP_TVAL_EN
          tval_d  = exc_tval;
`endif
          state_d = ST_SAVE_EPC;
        end else if (mret_valid) begin
          exc_ack = 1'b1;
          state_d = ST_RST_STATUS;
        end else begin
          stall = 1'b0;
          csr   = ins_csr;
          csr_w = ins_req & ins_csr_w;
          wd    = ins_wd;
        end
      end
      ST_SAVE_EPC: begin
        csr_w   = 1'b1;
        csr     = CSR_MEPC;
        wd      = {pc_q, 2'b00};
        state_d = ST_SAVE_CAUSE;
      end
      ST_SAVE_CAUSE: begin
        csr_w   = 1'b1;
        csr     = CSR_MCAUSE;
        wd      = XLEN'(cause_q);
`ifdef CSR_TRAP_TVAL_EN
        state_d = ST_SAVE_TVAL;
`else
        state_d = ST_UPD_STATUS;
`endif
      end
`ifdef CSR_TRAP_TVAL_EN
      ST_SAVE_TVAL: begin
        csr_w   = 1'b1;
        csr     = CSR_MTVAL;
        wd      = tval_q;
        state_d = ST_UPD_STATUS;
      end
`endif
      // mstatus is read and rewritten in one cycle through the combinational rd path
      ST_UPD_STATUS: begin
        csr_w             = 1'b1;
        csr               = CSR_MSTATUS;
        wd                = rd;
        wd[MSTATUS_MPIE]  = rd[MSTATUS_MIE];
        wd[MSTATUS_MIE]   = 1'b0;
        state_d           = ST_VEC_TRAP;
      end
      ST_VEC_TRAP: begin
        csr         = CSR_MTVEC;
        redir_valid = 1'b1;
        redir_pc    = {rd[XLEN-1:2], 2'b00};
        state_d     = ST_IDLE;
      end
      ST_RST_STATUS: begin
        csr              = CSR_MSTATUS;
        csr_w            = 1'b1;
        wd               = rd;
        wd[MSTATUS_MIE]  = rd[MSTATUS_MPIE];
        wd[MSTATUS_MPIE] = 1'b1;
        state_d          = ST_VEC_MRET;
      end
      ST_VEC_MRET: begin
        csr         = CSR_MEPC;
        redir_valid = 1'b1;
        redir_pc    = rd;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are forced quiet while reset is asserted so no write can land mid-abort
    if (!rst_n) begin
      exc_ack     = 1'b0;
      csr_w       = 1'b0;
      csr         = '0;
      wd          = '0;
      stall       = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = '0;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl with a behavioural CSR file and
// transaction-level expectations for traps, MRET and pass-through.
module tb_csr_trap_ctrl;
  import csr_pkg::*;

`ifdef CSR_TRAP_TVAL_EN
  localparam bit TVAL_EN = 1'b1;
`else
  localparam bit TVAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_req, ins_csr_w;
  logic [11:0] ins_csr;
  logic [31:0] ins_wd;
  logic        exc_valid, mret_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        exc_ack, csr_w, stall, redir_valid;
  logic [11:0] csr;
  logic [31:0] wd, rd, redir_pc;

  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [31:0] pl_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_req(ins_req), .ins_csr_w(ins_csr_w), .ins_csr(ins_csr), .ins_wd(ins_wd),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .exc_ack(exc_ack),
    .csr_w(csr_w), .csr(csr), .wd(wd), .rd(rd),
    .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc)
  );

  // Behavioural CSR block: combinational read, write on rising edge
  assign rd = mem[csr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (csr_w) mem[csr] <= wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic pass_vec(input string tag, input logic req, input logic w,
                          input logic [11:0] idx, input logic [31:0] dat, input logic exp_w);
    ins_req = req; ins_csr_w = w; ins_csr = idx; ins_wd = dat;
    @(negedge clk);
    chk({tag, " csr_w"}, 32'(csr_w), 32'(exp_w));
    chk({tag, " csr"}, 32'(csr), 32'(idx));
    chk({tag, " wd"}, wd, dat);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " ack"}, 32'(exc_ack), 32'd0);
    @(posedge clk); #1;
    if (exp_w) chk({tag, " written"}, mem[idx], dat);
    ins_req = 1'b0; ins_csr_w = 1'b0;
  endtask

  // Entered and left at posedge+1. Expectations come from the architectural
  // effect of a trap/MRET, not from the controller's internal sequencing.
  task automatic run_event(input string tag, input bit is_trap, input bit also_mret,
                           input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                           input bit ins_on, input logic [11:0] ins_idx, input logic [31:0] ins_val);
    logic [31:0] ms, tv, ep, mt0, exp_ms, exp_redir, got_redir;
    int exp_lat, acks, redirs, redir_cyc, stall_low, inv_bad;
    bit done;
    ms = mem[CSR_MSTATUS]; tv = mem[CSR_MTVEC]; ep = mem[CSR_MEPC]; mt0 = mem[CSR_MTVAL];
    exp_ms = ms;
    if (is_trap) begin
      exp_ms[7] = ms[3]; exp_ms[3] = 1'b0;
      exp_redir = tv & 32'hFFFF_FFFC;
      exp_lat   = TVAL_EN ? 5 : 4;
    end else begin
      exp_ms[3] = ms[7]; exp_ms[7] = 1'b1;
      exp_redir = ep;
      exp_lat   = 2;
    end
    acks = 0; redirs = 0; redir_cyc = -1; stall_low = 0; inv_bad = 0; done = 0; got_redir = '0;
    exc_valid = is_trap; mret_valid = !is_trap || also_mret;
    exc_cause = cause; exc_pc = pc; exc_tval = tval;
    ins_req = ins_on; ins_csr_w = 1'b1; ins_csr = ins_idx; ins_wd = ins_val;
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, " accept csr_w"}, 32'(csr_w), 32'd0);
      acks += int'(exc_ack);
      if (!stall) stall_low++;
      if (!csr_w && wd != 0) inv_bad++;
      if (!redir_valid && redir_pc != 0) inv_bad++;
      if (!TVAL_EN && csr_w && csr == CSR_MTVAL) inv_bad++;
      if (redir_valid) begin
        redirs++;
        if (redir_cyc < 0) begin redir_cyc = cyc; got_redir = redir_pc; end
      end
      @(posedge clk); #1;
      if (cyc == 0) begin
        exc_valid = 1'b0;
        if (!also_mret) mret_valid = 1'b0;
      end
      if (redirs > 0) done = 1;
    end
    ins_req = 1'b0;
    chk({tag, " ack count"}, 32'(acks), 32'd1);
    chk({tag, " redirect cycle"}, 32'(redir_cyc), 32'(exp_lat));
    chk({tag, " redirect pc"}, got_redir, exp_redir);
    chk({tag, " stall low cycles"}, 32'(stall_low), 32'd0);
    chk({tag, " idle-port violations"}, 32'(inv_bad), 32'd0);
    chk({tag, " mstatus"}, mem[CSR_MSTATUS], exp_ms);
    if (is_trap) begin
      chk({tag, " mepc"}, mem[CSR_MEPC], pc & 32'hFFFF_FFFC);
      chk({tag, " mcause"}, mem[CSR_MCAUSE], {28'd0, cause});
      chk({tag, " mtval"}, mem[CSR_MTVAL], TVAL_EN ? tval : mt0);
    end
    if (!also_mret) begin
      @(negedge clk);
      chk({tag, " single redirect"}, 32'(redir_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        req;
    logic        w;
    logic [11:0] idx;
    logic [31:0] dat;
    logic        exp_w;
  } pt_vec_t;

  pt_vec_t pt_tab [5];

  initial begin
    pt_tab[0] = '{1'b1, 1'b1, 12'h005, 32'd100,       1'b1};
    pt_tab[1] = '{1'b1, 1'b0, 12'h041, 32'h1234_5678, 1'b0};
    pt_tab[2] = '{1'b0, 1'b1, 12'h042, 32'hFFFF_FFFF, 1'b0};
    pt_tab[3] = '{1'b1, 1'b1, 12'h7C0, 32'hA5A5_0001, 1'b1};
    pt_tab[4] = '{1'b1, 1'b1, 12'h000, 32'h0000_0008, 1'b1};

    rst_n = 1'b0;
    ins_req = 1'b1; ins_csr_w = 1'b1; ins_csr = 12'h005; ins_wd = 32'hFFFF_FFFF;
    exc_valid = 1'b0; mret_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset csr_w", 32'(csr_w), 32'd0);
    chk("reset csr", 32'(csr), 32'd0);
    chk("reset wd", wd, 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset ack", 32'(exc_ack), 32'd0);
    chk("reset redir", {31'd0, redir_valid} | redir_pc, 32'd0);
    ins_req = 1'b0; ins_csr_w = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      pass_vec($sformatf("pt%0d", i), pt_tab[i].req, pt_tab[i].w, pt_tab[i].idx,
               pt_tab[i].dat, pt_tab[i].exp_w);
    chk("mtvec after pass-through", mem[CSR_MTVEC], 32'd100);

    preload(CSR_MTVEC, 32'h0000_0100);
    preload(CSR_MSTATUS, 32'h0000_0008);
    preload(CSR_MTVAL, 32'h5A5A_5A5A);
    run_event("ecall", 1, 0, CAUSE_ECALL_M, 32'h18, 32'hDEAD_BEEF, 0, 12'h0, 32'h0);

    preload(CSR_MEPC, 32'h0000_001C);
    preload(CSR_MSTATUS, 32'h0000_0080);
    run_event("mret", 0, 0, 4'd0, 32'h0, 32'h0, 0, 12'h0, 32'h0);

    preload(CSR_MTVEC, 32'h0000_0203);
    preload(CSR_MSTATUS, 32'h0000_0008);
    run_event("collide trap", 1, 1, CAUSE_ECALL_M, 32'h0000_0018, 32'h0, 1, CSR_MTVEC, 32'hBAD0_0BAD);
    run_event("collide mret", 0, 0, 4'd0, 32'h0, 32'h0, 0, 12'h0, 32'h0);

    preload(CSR_MCAUSE, 32'h0000_0077);
    exc_valid = 1'b1; exc_cause = CAUSE_BREAKPOINT; exc_pc = 32'h40;
    ins_req = 1'b1; ins_csr_w = 1'b1; ins_csr = CSR_MTVEC; ins_wd = 32'h0000_0300;
    @(posedge clk); #1;
    exc_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst mid csr in SAVE_CAUSE", 32'(csr), 32'(CSR_MCAUSE));
    #3 rst_n = 1'b0;
    #1;
    chk("rst mid csr_w", 32'(csr_w), 32'd0);
    chk("rst mid wd|csr", wd | 32'(csr), 32'd0);
    chk("rst mid stall", 32'(stall), 32'd0);
    chk("rst mid redir", {31'd0, redir_valid} | redir_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst mid mcause kept", mem[CSR_MCAUSE], 32'h0000_0077);
    #1;
    chk("rst release idle stall", 32'(stall), 32'd0);
    chk("rst release pass-through", 32'(csr_w), 32'd1);
    @(posedge clk); #1;
    ins_req = 1'b0; ins_csr_w = 1'b0;

    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [11:0] ridx;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: ridx = CSR_MSTATUS;
        1: ridx = CSR_MTVEC;
        2: ridx = CSR_MEPC;
        3: ridx = CSR_MCAUSE;
        default: ridx = CSR_MTVAL;
      endcase
      if (kind == 0) begin
        logic rq, rw;
        rq = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
        pass_vec($sformatf("rnd%0d pt", n), rq, rw, ridx, $urandom, rq & rw);
      end else if (kind == 1) begin
        preload(CSR_MSTATUS, $urandom);
        preload(CSR_MTVEC, $urandom);
        preload(CSR_MTVAL, $urandom);
        run_event($sformatf("rnd%0d trap", n), 1, 0, 4'($urandom_range(0, 15)), $urandom,
                  $urandom, 1'($urandom_range(0, 1)), ridx, $urandom);
      end else begin
        preload(CSR_MSTATUS, $urandom);
        preload(CSR_MEPC, $urandom);
        run_event($sformatf("rnd%0d mret", n), 0, 0, 4'd0, 32'h0, 32'h0,
                  1'($urandom_range(0, 1)), ridx, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
